// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA transfer sequencer and its helpers.
package dma_pkg;

  localparam int unsigned DMA_W       = 8;
  localparam int unsigned DMA_SLICE_W = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    WAIT = 3'd2,
    REQ  = 3'd3,
    STEP = 3'd4,
    DONE = 3'd5
  } state_e;

endpackage : dma_pkg

// File: rtl/dma_term_detect.sv
// End-of-block detector evaluated on pre-update counter values.
// With DMA_XFER_CTRL_ADDR_STOP_EN defined, an address match also terminates the block.
module dma_term_detect
  import dma_pkg::*;
#(
  parameter int unsigned W = DMA_W
) (
`ifdef DMA_XFER_CTRL_ADDR_STOP_EN
  input  logic [W-1:0] addr_count,
  input  logic [W-1:0] addr_stop,
`endif
  input  logic [W-1:0] wc_count,
  output logic         last_c
);

`ifdef DMA_XFER_CTRL_ADDR_STOP_EN
  assign last_c = (wc_count == W'(1)) || (addr_count == addr_stop);
`else
  assign last_c = (wc_count == W'(1));
`endif

endmodule : dma_term_detect

// File: rtl/dma_xfer_ctrl.sv
// Transfer sequencer driving load/enable/direction/carry of the cascaded address and
// word-count chains. Optional address-stop termination: DMA_XFER_CTRL_ADDR_STOP_EN.
module dma_xfer_ctrl
  import dma_pkg::*;
#(
  parameter int unsigned W = DMA_W
) (
  input  logic         clk,
  input  logic         res_n,
  input  logic         start,
  input  logic         abort,
  input  logic         dir,
  input  logic         dreq,
  input  logic         bus_ack,
  input  logic [W-1:0] wc_count,
  input  logic [W-1:0] addr_count,
`ifdef DMA_XFER_CTRL_ADDR_STOP_EN
  input  logic [W-1:0] addr_stop,
`endif
  output logic         addr_ld,
  output logic         wc_ld,
  output logic         addr_en,
  output logic         wc_en,
  output logic         addr_ci,
  output logic         wc_ci,
  output logic         addr_up,
  output logic         wc_up,
  output logic         bus_req,
  output logic         busy,
  output logic         done
);

  state_e state_q, state_d;
  logic   dir_q, dir_d;
  logic   ld_q, ld_d;
  logic   step_q, step_d;
  logic   req_q, req_d;
  logic   busy_q, busy_d;
  logic   done_q, done_d;
  logic   last_c;

`ifdef DMA_XFER_CTRL_ADDR_STOP_EN
  dma_term_detect #(.W(W)) u_term (
    .addr_count (addr_count),
    .addr_stop  (addr_stop),
    .wc_count   (wc_count),
    .last_c     (last_c)
  );
`else
  logic unused_addr_count;
  assign unused_addr_count = ^addr_count;

  dma_term_detect #(.W(W)) u_term (
    .wc_count (wc_count),
    .last_c   (last_c)
  );
`endif

  // Next state; outputs are decoded from the next state so they register in step with it.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = LOAD;
          dir_d   = dir;
        end
      end
      LOAD:    state_d = WAIT;
      WAIT:    if (dreq) state_d = REQ;
      REQ:     if (bus_ack) state_d = STEP;
      STEP:    state_d = last_c ? DONE : WAIT;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && (state_q != IDLE)) state_d = IDLE;

    ld_d   = (state_d == LOAD);
    step_d = (state_d == STEP);
    req_d  = (state_d == REQ);
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q <= IDLE;
      dir_q   <= 1'b1;
      ld_q    <= 1'b0;
      step_q  <= 1'b0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      ld_q    <= ld_d;
      step_q  <= step_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Carry-in to the LS slice mirrors the enable; word count always counts down.
  assign addr_ld = ld_q;
  assign wc_ld   = ld_q;
  assign addr_en = step_q;
  assign wc_en   = step_q;
  assign addr_ci = step_q;
  assign wc_ci   = step_q;
  assign addr_up = dir_q;
  assign wc_up   = 1'b0;
  assign bus_req = req_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule : dma_xfer_ctrl

// File: tb/tb_dma_xfer_ctrl.sv
// Directed self-checking bench for dma_xfer_ctrl with a behavioural model of the
// counter chains closing the loop.
module tb_dma_xfer_ctrl;
  import dma_pkg::*;

  localparam int unsigned W = DMA_W;

  logic         clk = 1'b0;
  logic         res_n, start, abort, dir, dreq, bus_ack;
  logic [W-1:0] wc_count, addr_count, wc_init, addr_init;
`ifdef DMA_XFER_CTRL_ADDR_STOP_EN
  logic [W-1:0] addr_stop;
`endif
  logic addr_ld, wc_ld, addr_en, wc_en, addr_ci, wc_ci, addr_up, wc_up;
  logic bus_req, busy, done;

  int checks = 0;
  int passed = 0;

  dma_xfer_ctrl #(.W(W)) dut (
    .clk        (clk),
    .res_n      (res_n),
    .start      (start),
    .abort      (abort),
    .dir        (dir),
    .dreq       (dreq),
    .bus_ack    (bus_ack),
    .wc_count   (wc_count),
    .addr_count (addr_count),
`ifdef DMA_XFER_CTRL_ADDR_STOP_EN
    .addr_stop  (addr_stop),
`endif
    .addr_ld    (addr_ld),
    .wc_ld      (wc_ld),
    .addr_en    (addr_en),
    .wc_en      (wc_en),
    .addr_ci    (addr_ci),
    .wc_ci      (wc_ci),
    .addr_up    (addr_up),
    .wc_up      (wc_up),
    .bus_req    (bus_req),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Counter chains as seen by the sequencer.
  always @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      wc_count   <= '0;
      addr_count <= '0;
    end else begin
      if (wc_ld) wc_count <= wc_init;
      else if (wc_en && wc_ci) wc_count <= wc_up ? wc_count + W'(1) : wc_count - W'(1);
      if (addr_ld) addr_count <= addr_init;
      else if (addr_en && addr_ci) addr_count <= addr_up ? addr_count + W'(1) : addr_count - W'(1);
    end
  end

  task automatic test_reset();
    logic [10:0] outs;
    res_n = 1'b0; start = 1'b0; abort = 1'b0; dir = 1'b0; dreq = 1'b0; bus_ack = 1'b0;
    wc_init = '0; addr_init = '0;
    repeat (2) @(negedge clk);
    outs = {addr_ld, wc_ld, addr_en, wc_en, addr_ci, wc_ci, addr_up, wc_up, bus_req, busy, done};
    checks++;
    if (outs !== 11'b000000_1_0000) $display("FAIL reset_outs: got %b expected %b", outs, 11'b00000010000);
    else passed++;
    checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy);
    else passed++;
    res_n = 1'b1;
    @(negedge clk);
    start = 1'b1; abort = 1'b1; dir = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) $display("FAIL abort_beats_start_busy: got %b expected 0", busy);
    else passed++;
    checks++;
    if (wc_ld !== 1'b0) $display("FAIL abort_beats_start_ld: got %b expected 0", wc_ld);
    else passed++;
    checks++;
    if (addr_up !== 1'b1) $display("FAIL abort_beats_start_dir: got %b expected 1", addr_up);
    else passed++;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int step_cnt = 0, done_cnt = 0, first_step = 0, last_step = 0, gap_bad = 0;
    int done_cyc = 0, up_bad = 0, ld_cnt = 0;
    logic ld1 = 1'b0, busy12 = 1'b1;
    dreq = 1'b1; bus_ack = 1'b1; wc_init = W'(3); addr_init = W'(8'h40); dir = 1'b1; start = 1'b1;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin start = 1'b0; ld1 = wc_ld & addr_ld; end
      if (wc_ld) ld_cnt++;
      if (addr_en) begin
        step_cnt++;
        if (last_step != 0 && cyc - last_step != 3) gap_bad++;
        if (first_step == 0) first_step = cyc;
        last_step = cyc;
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (busy && !addr_up) up_bad++;
      if (cyc == 12) busy12 = busy;
    end
    checks++;
    if (ld1 !== 1'b1 || ld_cnt != 1) $display("FAIL basic_load: got ld1=%b count=%0d expected 1/1", ld1, ld_cnt);
    else passed++;
    checks++;
    if (step_cnt != 3) $display("FAIL basic_steps: got %0d expected 3", step_cnt);
    else passed++;
    checks++;
    if (first_step != 4 || gap_bad != 0) $display("FAIL basic_step_timing: got first=%0d gaps_bad=%0d expected 4/0", first_step, gap_bad);
    else passed++;
    checks++;
    if (done_cnt != 1 || done_cyc != 11) $display("FAIL basic_done: got count=%0d cyc=%0d expected 1/11", done_cnt, done_cyc);
    else passed++;
    checks++;
    if (up_bad != 0) $display("FAIL basic_addr_up: got %0d bad cycles expected 0", up_bad);
    else passed++;
    checks++;
    if (busy12 !== 1'b0) $display("FAIL basic_busy_fall: got %b expected 0", busy12);
    else passed++;
    checks++;
    if (wc_count !== W'(0)) $display("FAIL basic_wc_final: got %0d expected 0", wc_count);
    else passed++;
  endtask

  task automatic test_ack_delay();
    int step_cnt = 0, done_cnt = 0, done_cyc = 0, up_bad = 0, req_first = 0, req_w1 = 0;
    dreq = 1'b1; bus_ack = 1'b0; wc_init = W'(2); addr_init = W'(8'h80); dir = 1'b0; start = 1'b1;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start = 1'b0;
      if (bus_req && req_first == 0) req_first = cyc;
      if (bus_req && step_cnt == 0) req_w1++;
      if (addr_en) step_cnt++;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (busy && addr_up) up_bad++;
      if (cyc == 7) bus_ack = 1'b1;
    end
    checks++;
    if (req_first != 3) $display("FAIL delay_req_start: got %0d expected 3", req_first);
    else passed++;
    checks++;
    if (req_w1 != 5) $display("FAIL delay_req_hold: got %0d expected 5", req_w1);
    else passed++;
    checks++;
    if (step_cnt != 2) $display("FAIL delay_steps: got %0d expected 2", step_cnt);
    else passed++;
    checks++;
    if (done_cnt != 1 || done_cyc != 12) $display("FAIL delay_done: got count=%0d cyc=%0d expected 1/12", done_cnt, done_cyc);
    else passed++;
    checks++;
    if (up_bad != 0) $display("FAIL delay_addr_up: got %0d bad cycles expected 0", up_bad);
    else passed++;
  endtask

  task automatic test_abort();
    int step_cnt = 0, done_cnt = 0, late_bad = 0;
    logic req7 = 1'b0, busy8 = 1'b1, req8 = 1'b1;
    dreq = 1'b1; bus_ack = 1'b1; wc_init = W'(5); addr_init = W'(0); dir = 1'b1; start = 1'b1;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start = 1'b0;
      if (addr_en) step_cnt++;
      if (done) done_cnt++;
      if (cyc >= 8 && (addr_en || wc_en || wc_ld || bus_req || busy)) late_bad++;
      if (cyc == 4) bus_ack = 1'b0;
      if (cyc == 7) begin req7 = bus_req; abort = 1'b1; end
      if (cyc == 8) begin busy8 = busy; req8 = bus_req; abort = 1'b0; end
    end
    bus_ack = 1'b1;
    checks++;
    if (req7 !== 1'b1) $display("FAIL abort_in_req: got bus_req=%b expected 1", req7);
    else passed++;
    checks++;
    if (busy8 !== 1'b0 || req8 !== 1'b0) $display("FAIL abort_idle: got busy=%b bus_req=%b expected 0/0", busy8, req8);
    else passed++;
    checks++;
    if (step_cnt != 1) $display("FAIL abort_steps: got %0d expected 1", step_cnt);
    else passed++;
    checks++;
    if (done_cnt != 0) $display("FAIL abort_no_done: got %0d expected 0", done_cnt);
    else passed++;
    checks++;
    if (late_bad != 0) $display("FAIL abort_quiet: got %0d active cycles expected 0", late_bad);
    else passed++;
  endtask

  task automatic test_async_reset();
    logic req4 = 1'b0;
    dreq = 1'b1; bus_ack = 1'b0; wc_init = W'(4); dir = 1'b0; start = 1'b1;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start = 1'b0;
      if (cyc == 4) req4 = bus_req;
    end
    checks++;
    if (req4 !== 1'b1) $display("FAIL areset_pre_req: got %b expected 1", req4);
    else passed++;
    #2 res_n = 1'b0;
    #1;
    checks++;
    if (bus_req !== 1'b0 || busy !== 1'b0) $display("FAIL areset_drop: got bus_req=%b busy=%b expected 0/0", bus_req, busy);
    else passed++;
    checks++;
    if (addr_up !== 1'b1) $display("FAIL areset_dir: got %b expected 1", addr_up);
    else passed++;
    @(negedge clk);
    res_n = 1'b1; bus_ack = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_wrap();
    int step_cnt = 0, done_cnt = 0, done_cyc = 0, up_bad = 0;
    logic busy_after = 1'b1;
    dreq = 1'b1; bus_ack = 1'b1; wc_init = W'(0); addr_init = W'(0); dir = 1'b1; start = 1'b1;
    for (int cyc = 1; cyc <= 775; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start = 1'b0;
      if (addr_en) step_cnt++;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (busy && !addr_up) up_bad++;
      if (cyc == 771) busy_after = busy;
      if (cyc == 100) begin start = 1'b1; dir = 1'b0; end
      if (cyc == 101) begin start = 1'b0; dir = 1'b1; end
    end
    checks++;
    if (step_cnt != 256) $display("FAIL wrap_steps: got %0d expected 256", step_cnt);
    else passed++;
    checks++;
    if (done_cnt != 1 || done_cyc != 770) $display("FAIL wrap_done: got count=%0d cyc=%0d expected 1/770", done_cnt, done_cyc);
    else passed++;
    checks++;
    if (up_bad != 0) $display("FAIL wrap_start_ignored: got %0d bad cycles expected 0", up_bad);
    else passed++;
    checks++;
    if (busy_after !== 1'b0) $display("FAIL wrap_busy_fall: got %b expected 0", busy_after);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int step_cnt = 0, done_cyc = 0;
    dreq = 1'b1; bus_ack = 1'b1; wc_init = W'(1); dir = 1'b1; start = 1'b1;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start = 1'b0;
      if (addr_en) step_cnt++;
      if (done) done_cyc = cyc;
    end
    checks++;
    if (step_cnt != 1) $display("FAIL b2b_steps: got %0d expected 1", step_cnt);
    else passed++;
    checks++;
    if (done_cyc != 5) $display("FAIL b2b_done: got cyc=%0d expected 5", done_cyc);
    else passed++;
  endtask

`ifdef DMA_XFER_CTRL_ADDR_STOP_EN
  task automatic test_addr_stop();
    int step_cnt = 0, done_cnt = 0, done_cyc = 0;
    dreq = 1'b1; bus_ack = 1'b1; wc_init = W'(10); addr_init = W'(8'h20);
    addr_stop = W'(8'h23); dir = 1'b1; start = 1'b1;
    for (int cyc = 1; cyc <= 18; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start = 1'b0;
      if (addr_en) step_cnt++;
      if (done) begin done_cnt++; done_cyc = cyc; end
    end
    checks++;
    if (step_cnt != 4) $display("FAIL astop_steps: got %0d expected 4", step_cnt);
    else passed++;
    checks++;
    if (done_cnt != 1 || done_cyc != 14) $display("FAIL astop_done: got count=%0d cyc=%0d expected 1/14", done_cnt, done_cyc);
    else passed++;
    checks++;
    if (wc_count !== W'(6)) $display("FAIL astop_wc: got %0d expected 6", wc_count);
    else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_ack_delay();
    test_abort();
    test_async_reset();
    test_wrap();
    test_back_to_back();
`ifdef DMA_XFER_CTRL_ADDR_STOP_EN
    test_addr_stop();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule : tb_dma_xfer_ctrl
